quad_tx: RTL
============

Name: quad_tx

Overview:
- Quadrature encoder emulator: the transmit-side counterpart of the encoder decoder.
- Accepts step requests (direction plus step count) over a valid/ready handshake and drives A/B quadrature waveforms at a programmable edge rate.
- Used in hardware-in-the-loop tests, driving the encoder inputs of the lab top level. It also keeps a running position count that can be compared with the receiver's count on the 7-segment display.

Parameters:
- DIV_W, 16, width of the edge-period field in clocks.
- CNT_W, 8, width of the step-count and position fields.

Ports:
- clk  input  1  system clock (50 MHz).
- reset_n  input  1  synchronous active-low reset.
- period  input  DIV_W  clocks per quadrature edge; sampled at request accept; 0 is treated as 1.
- req_valid  input  1  step request valid.
- req_dir  input  1  1 = CW, 0 = CCW.
- req_steps  input  CNT_W  number of full quadrature cycles to emit.
- req_ready  output  1  high only in IDLE.
- a  output  1  quadrature channel A.
- b  output  1  quadrature channel B.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a request completes.
- pos  output  CNT_W  signed-wrap position, +1 per completed CW step, -1 per completed CCW step.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, on reset_n.
- Reset (reset_n low at a clk rising edge):
  - state = IDLE; a = b = 0; pos = 0; done = 0; busy = 0; req_ready = 1 the following cycle.
  - Internal divider, phase and remaining-step counters cleared.
  - Reset mid-RUN aborts immediately. a/b go to 00 at that edge even though this is a non-quadrature jump; no done pulse.
- All outputs are registered. req_ready equals state==IDLE.
- Accept occurs when req_valid && req_ready at an edge. On accept, latch:
  - dir = req_dir;
  - rem = req_steps;
  - per = max(period, 1).
- Accept with req_steps == 0: stay IDLE and pulse done for 1 cycle, starting the cycle after accept. No a/b activity; pos unchanged.
- Accept with req_steps != 0: go to RUN with div = 0.
- RUN behaviour:
  - div increments every clock.
  - When div == per-1: div <= 0 and the phase advances one quadrature edge.
  - First a/b change occurs exactly per clocks after the accept edge. Consecutive edges are per clocks apart.
- Phase sequence {a,b}:
  - CW: 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  - CCW: 00 -> 01 -> 11 -> 10 -> 00.
  - Rest state is 00. One step = 4 edges ending at 00.
- Edge that returns {a,b} to 00 completes a step, all in the same clock:
  - rem decrements;
  - pos +1 (CW) or -1 (CCW), wrapping modulo 2^CNT_W (0xFF + 1 = 0x00; 0x00 - 1 = 0xFF).
- If the completing step takes rem to 0, in that same edge:
  - state goes to IDLE and done asserts for exactly 1 cycle;
  - busy drops; req_ready rises.
  - A new request may be accepted on the following edge (back-to-back requests allowed, no idle gap required).
- req_valid, req_dir and req_steps are ignored while busy. The requester must hold req_valid until accepted.
- period changes during RUN have no effect, since it is sampled only at accept.
- Never more than one bit of {a,b} changes per edge, except on reset.

Optional Feature:
- Macro: QUAD_TX_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort high in RUN clears rem to 1, so the current step finishes to rest 00 at the normal rate. The unit then returns to IDLE with a done pulse, and pos is counted for that final step.
  - abort in IDLE is ignored.
  - abort coinciding with the completing edge of the last step is equivalent to normal completion.
- Undefined: no abort port; every request always runs to completion.

Test Plan:
- Reset then idle: reset_n low 2 cycles -> a=b=0, pos=0x00, req_ready=1, busy=0, done=0.
- period=4, CW, steps=1, accepted at edge T:
  - {a,b} = 10@T+4, 11@T+8, 01@T+12, 00@T+16;
  - pos=0x01 and done=1 at T+16 only; req_ready=1 at T+16.
- period=0, CCW, steps=2 from pos=0x00:
  - edges every clock in order 01,11,10,00,01,11,10,00;
  - pos=0xFF then 0xFE; one done pulse.
- Back-to-back requests: CW 3 steps then CCW 3 steps, req_valid held high -> second request accepted the edge after the first done; final pos returns to its start value.
- req_steps=0 -> done pulses the cycle after accept; a/b stay 00; pos unchanged.
- Reset asserted mid-step at {a,b}=11 -> next edge a=b=0, pos=0, IDLE, no done. With QUAD_TX_ABORT_EN, abort at 11 in a 5-step CW request instead finishes through 01 to 00, pos +1 for that step, then done.

Source files
------------

// File: rtl/quad_tx.sv
// ============================================================================
// quad_tx : quadrature encoder emulator, steps A/B at a programmable edge rate
// Optional abort input enabled by defining QUAD_TX_ABORT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module quad_tx #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] period,
    input  logic             req_valid,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_steps,
`ifdef QUAD_TX_ABORT_EN
    input  logic             abort,
`endif
    output logic             req_ready,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic             dir_q;
    logic [CNT_W-1:0] rem_q;
    logic [DIV_W-1:0] per_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       phase_q;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             ready_q;
    logic             done_q;
    logic [CNT_W-1:0] pos_q;

    logic             abort_req;
    logic             tick_d;
    logic             step_done_d;
    logic [1:0]       phase_d;
    logic             a_d;
    logic             b_d;
    logic [CNT_W-1:0] pos_d;
    logic [DIV_W-1:0] per_d;

`ifdef QUAD_TX_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Phase index 0..3 walks 00,10,11,01 for CW; CCW is the same walk with A/B swapped.
    always_comb begin
        tick_d      = (div_q == (per_q - DIV_W'(1)));
        phase_d     = phase_q + 2'd1;
        step_done_d = tick_d && (phase_q == 2'd3);
        a_d         = (phase_d == 2'd1) || (phase_d == 2'd2);
        b_d         = (phase_d == 2'd2) || (phase_d == 2'd3);
        if (!dir_q) begin
            a_d = (phase_d == 2'd2) || (phase_d == 2'd3);
            b_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        end
        pos_d = dir_q ? (pos_q + CNT_W'(1)) : (pos_q - CNT_W'(1));
        per_d = (period == '0) ? DIV_W'(1) : period;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            per_q   <= DIV_W'(1);
            div_q   <= '0;
            phase_q <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        dir_q   <= req_dir;
                        rem_q   <= req_steps;
                        per_q   <= per_d;
                        div_q   <= '0;
                        phase_q <= 2'd0;
                        if (req_steps == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // An abort lets the step in flight finish at the normal rate.
                    if (abort_req && !step_done_d) begin
                        rem_q <= CNT_W'(1);
                    end
                    if (tick_d) begin
                        div_q   <= '0;
                        phase_q <= phase_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        if (step_done_d) begin
                            pos_q <= pos_d;
                            rem_q <= rem_q - CNT_W'(1);
                            if ((rem_q == CNT_W'(1)) || abort_req) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pos       = pos_q;

endmodule

`default_nettype wire
